// File: rtl/mem_wb_backend_if.sv
// Bundle of signals between the ID/EX/ALU side and the memory/write-back back end.
// The front end drives the ex_* fields and flush_ex. The back end returns the branch
// decision, the forwarding taps and the register-file write port.
// There is no valid/ready pairing here. A bubble is encoded as all-zero WB/M control.
interface mem_wb_backend_if;
   logic [1:0]  ex_WB;
   logic [3:0]  ex_M;
   logic [31:0] ex_alu_result;
   logic        ex_zero;
   logic [31:0] ex_store_data;
   logic [31:0] ex_branch_target;
   logic [4:0]  ex_dest_reg;
   logic        flush_ex;

   logic        PCsrc;
   logic [31:0] branch_target;
   logic        fwd_mem_reg_write;
   logic [4:0]  fwd_mem_reg;
   logic [31:0] fwd_mem_value;
   logic        fwd_mem_is_load;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;

   modport master (
      output ex_WB, ex_M, ex_alu_result, ex_zero, ex_store_data,
             ex_branch_target, ex_dest_reg, flush_ex,
      input  PCsrc, branch_target, fwd_mem_reg_write, fwd_mem_reg,
             fwd_mem_value, fwd_mem_is_load, wb_reg_write, wb_write_reg,
             wb_write_data
   );

   modport slave (
      input  ex_WB, ex_M, ex_alu_result, ex_zero, ex_store_data,
             ex_branch_target, ex_dest_reg, flush_ex,
      output PCsrc, branch_target, fwd_mem_reg_write, fwd_mem_reg,
             fwd_mem_value, fwd_mem_is_load, wb_reg_write, wb_write_reg,
             wb_write_data
   );
endinterface

// File: rtl/mem_wb_backend.sv
// Back half of the five-stage pipeline. It holds the EX/MEM register, the word-addressed
// data memory with branch resolution, and the MEM/WB register with the write-back mux.
// Every output is taken from registered state only.
module mem_wb_backend #(
   parameter int MEM_WORDS = 256,
   parameter int ADDR_BITS = 8
) (
   input logic clk,
   input logic rst,
   mem_wb_backend_if.slave bus
);

   // EX/MEM pipeline register fields
   logic [1:0]  exm_wb;
   logic [3:0]  exm_m;
   logic [31:0] exm_alu;
   logic        exm_zero;
   logic [31:0] exm_store;
   logic [31:0] exm_target;
   logic [4:0]  exm_dest;

   // MEM/WB pipeline register fields
   logic [1:0]  mwb_wb;
   logic [31:0] mwb_rdata;
   logic [31:0] mwb_alu;
   logic [4:0]  mwb_dest;

   logic [31:0]          mem [MEM_WORDS];
   logic [ADDR_BITS-1:0] mem_idx;
   logic [31:0]          mem_rdata;

   // The byte offset and the bits above the memory size are dropped, so addresses wrap.
   assign mem_idx = exm_alu[ADDR_BITS+1:2];

   // EX/MEM capture. A flush turns the slot into a bubble. Reset also zeroes the data fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         exm_wb     <= '0;
         exm_m      <= '0;
         exm_alu    <= '0;
         exm_zero   <= 1'b0;
         exm_store  <= '0;
         exm_target <= '0;
         exm_dest   <= '0;
      end else begin
         exm_wb     <= bus.flush_ex ? 2'b00 : bus.ex_WB;
         exm_m      <= bus.flush_ex ? 4'b0000 : bus.ex_M;
         exm_alu    <= bus.ex_alu_result;
         exm_zero   <= bus.ex_zero;
         exm_store  <= bus.ex_store_data;
         exm_target <= bus.ex_branch_target;
         exm_dest   <= bus.ex_dest_reg;
      end
   end

   // Data memory write. A store sitting in EX/MEM on a reset edge is dropped. Contents survive reset.
   always_ff @(posedge clk) begin
      if (!rst && exm_m[2]) begin
         mem[mem_idx] <= exm_store;
      end
   end

   // Combinational read. The value is only meaningful while MemRead is set.
   always_comb begin
      mem_rdata = '0;
      if (exm_m[3]) begin
         mem_rdata = mem[mem_idx];
      end
   end

   // MEM/WB capture. There is no flush, because an instruction past MEM always completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         mwb_wb    <= '0;
         mwb_rdata <= '0;
         mwb_alu   <= '0;
         mwb_dest  <= '0;
      end else begin
         mwb_wb    <= exm_wb;
         mwb_rdata <= mem_rdata;
         mwb_alu   <= exm_alu;
         mwb_dest  <= exm_dest;
      end
   end

   // Branch resolution from EX/MEM. BranchNotEqual inverts the sense of the zero flag.
   assign bus.PCsrc         = exm_m[1] & (exm_zero ^ exm_m[0]);
   assign bus.branch_target = exm_target;

   // Forwarding taps. Writes to $0 are never advertised.
   assign bus.fwd_mem_reg_write = exm_wb[1] & (exm_dest != 5'd0);
   assign bus.fwd_mem_reg       = exm_dest;
   assign bus.fwd_mem_value     = exm_alu;
   assign bus.fwd_mem_is_load   = exm_m[3];

   // Write-back mux and the $0-gated register-file write enable.
   assign bus.wb_reg_write  = mwb_wb[1] & (mwb_dest != 5'd0);
   assign bus.wb_write_reg  = mwb_dest;
   assign bus.wb_write_data = mwb_wb[0] ? mwb_rdata : mwb_alu;

endmodule

// File: tb/tb_mem_wb_backend.sv
// Directed bench for mem_wb_backend. Inputs are applied 1 ns after each rising edge,
// and outputs are sampled at the same point after the edge that should have moved them.
module tb_mem_wb_backend;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   logic [31:0] exp_q[$];

   mem_wb_backend_if bus();

   mem_wb_backend #(.MEM_WORDS(256), .ADDR_BITS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Present one EX-stage slot, then advance past the next rising edge.
   task automatic step(input logic [1:0] wb, input logic [3:0] m, input logic [31:0] alu,
                       input logic zero, input logic [31:0] store, input logic [31:0] target,
                       input logic [4:0] dest, input logic flush);
      bus.ex_WB            = wb;
      bus.ex_M             = m;
      bus.ex_alu_result    = alu;
      bus.ex_zero          = zero;
      bus.ex_store_data    = store;
      bus.ex_branch_target = target;
      bus.ex_dest_reg      = dest;
      bus.flush_ex         = flush;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(2'b00, 4'b0000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      step(2'b00, 4'b0100, addr, 1'b0, data, 32'h0, 5'd0, 1'b0);
   endtask

   task automatic load(input logic [31:0] addr, input logic [4:0] dest);
      step(2'b11, 4'b1000, addr, 1'b0, 32'h0, 32'h0, dest, 1'b0);
   endtask

   // Load one word, then check that it reaches the register-file port one edge later.
   task automatic load_check(input string tag, input logic [31:0] addr, input logic [4:0] dest,
                             input logic [31:0] exp);
      load(addr, dest);
      exp_q.push_back(exp);
      idle();
      check({tag, "_we"}, {31'b0, bus.wb_reg_write}, 32'd1);
      check({tag, "_reg"}, {27'b0, bus.wb_write_reg}, {27'b0, dest});
      check({tag, "_data"}, bus.wb_write_data, exp_q.pop_front());
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      idle();
      rst = 1'b0;

      // Preload word 5. The idle slot lets the store commit before reset arrives.
      store(32'h14, 32'hDEADBEEF);
      idle();

      // Reset held two cycles with random inputs
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(2'($urandom), 4'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
              5'($urandom), 1'($urandom));
      end
      check("rst_pcsrc", {31'b0, bus.PCsrc}, 32'd0);
      check("rst_target", bus.branch_target, 32'd0);
      check("rst_fwd_we", {31'b0, bus.fwd_mem_reg_write}, 32'd0);
      check("rst_fwd_reg", {27'b0, bus.fwd_mem_reg}, 32'd0);
      check("rst_fwd_val", bus.fwd_mem_value, 32'd0);
      check("rst_fwd_ld", {31'b0, bus.fwd_mem_is_load}, 32'd0);
      check("rst_wb_we", {31'b0, bus.wb_reg_write}, 32'd0);
      check("rst_wb_reg", {27'b0, bus.wb_write_reg}, 32'd0);
      check("rst_wb_data", bus.wb_write_data, 32'd0);
      rst = 1'b0;
      load_check("preload", 32'h14, 5'd3, 32'hDEADBEEF);

      // ALU write-back
      step(2'b10, 4'b0000, 32'h1234, 1'b0, 32'h0, 32'h0, 5'd8, 1'b0);
      check("alu_fwd_reg", {27'b0, bus.fwd_mem_reg}, 32'd8);
      check("alu_fwd_val", bus.fwd_mem_value, 32'h1234);
      check("alu_fwd_we", {31'b0, bus.fwd_mem_reg_write}, 32'd1);
      check("alu_wb_early", {31'b0, bus.wb_reg_write}, 32'd0);
      idle();
      check("alu_wb_we", {31'b0, bus.wb_reg_write}, 32'd1);
      check("alu_wb_reg", {27'b0, bus.wb_write_reg}, 32'd8);
      check("alu_wb_data", bus.wb_write_data, 32'h1234);

      // Store, then load the same word in the next slot. A second load goes through an aliased address.
      store(32'h40, 32'hCAFEF00D);
      load(32'h43, 5'd9);
      check("ld_fwd_is_load", {31'b0, bus.fwd_mem_is_load}, 32'd1);
      idle();
      check("sl_we", {31'b0, bus.wb_reg_write}, 32'd1);
      check("sl_reg", {27'b0, bus.wb_write_reg}, 32'd9);
      check("sl_data", bus.wb_write_data, 32'hCAFEF00D);
      load_check("alias", 32'h440, 5'd10, 32'hCAFEF00D);

      // Branches
      step(2'b00, 4'b0010, 32'h0, 1'b1, 32'h0, 32'h100, 5'd0, 1'b0);
      check("beq_taken", {31'b0, bus.PCsrc}, 32'd1);
      check("beq_target", bus.branch_target, 32'h100);
      idle();
      check("beq_one_cycle", {31'b0, bus.PCsrc}, 32'd0);
      step(2'b00, 4'b0011, 32'h0, 1'b1, 32'h0, 32'h200, 5'd0, 1'b0);
      check("bne_zero1", {31'b0, bus.PCsrc}, 32'd0);
      step(2'b00, 4'b0011, 32'h0, 1'b0, 32'h0, 32'h300, 5'd0, 1'b0);
      check("bne_zero0", {31'b0, bus.PCsrc}, 32'd1);
      check("bne_target", bus.branch_target, 32'h300);
      step(2'b00, 4'b0010, 32'h0, 1'b0, 32'h0, 32'h400, 5'd0, 1'b0);
      check("beq_zero0", {31'b0, bus.PCsrc}, 32'd0);

      // Flushed store/branch/regwrite must leave no trace
      step(2'b10, 4'b0110, 32'h40, 1'b1, 32'h11111111, 32'h500, 5'd5, 1'b1);
      check("flush_pcsrc_n", {31'b0, bus.PCsrc}, 32'd0);
      check("flush_fwd_we", {31'b0, bus.fwd_mem_reg_write}, 32'd0);
      idle();
      check("flush_wb_n1", {31'b0, bus.wb_reg_write}, 32'd0);
      check("flush_pcsrc_n1", {31'b0, bus.PCsrc}, 32'd0);
      idle();
      check("flush_wb_n2", {31'b0, bus.wb_reg_write}, 32'd0);
      load_check("flush_mem", 32'h40, 5'd9, 32'hCAFEF00D);

      // Writes to $0 are suppressed
      step(2'b10, 4'b0000, 32'h55, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      check("r0_fwd_we", {31'b0, bus.fwd_mem_reg_write}, 32'd0);
      idle();
      check("r0_wb_we", {31'b0, bus.wb_reg_write}, 32'd0);
      check("r0_wb_data", bus.wb_write_data, 32'h55);

      // Reset while a load sits in EX/MEM
      load(32'h40, 5'd4);
      rst = 1'b1;
      idle();
      check("mrst_wb_we", {31'b0, bus.wb_reg_write}, 32'd0);
      check("mrst_fwd_ld", {31'b0, bus.fwd_mem_is_load}, 32'd0);
      rst = 1'b0;
      idle();
      check("mrst_wb_we2", {31'b0, bus.wb_reg_write}, 32'd0);

      // Reset while a store sits in EX/MEM drops the store
      store(32'h40, 32'h22222222);
      rst = 1'b1;
      idle();
      rst = 1'b0;
      load_check("mrst_store", 32'h40, 5'd6, 32'hCAFEF00D);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
